// File: rtl/riscv_bp_pkg.sv
// Shared branch-prediction types: PC width, queue depth, queue entry and resolve FSM states.
package riscv_bp_pkg;

  localparam int unsigned BP_PC_LEN  = 64;
  localparam int unsigned BP_Q_DEPTH = 4;

  typedef struct packed {
    logic [BP_PC_LEN-1:0] pc;
    logic                 pred_valid;
    logic                 pred_taken;
    logic [BP_PC_LEN-1:0] pred_target;
  } bp_pred_t;

  typedef enum logic {
    BP_RUN     = 1'b0,
    BP_RECOVER = 1'b1
  } bp_state_e;

endpackage

// File: rtl/bp_pred_fifo.sv
// Synchronous FIFO of in-flight predictions; flush empties it and wins over push/pop.
module bp_pred_fifo
  import riscv_bp_pkg::*;
#(
  parameter int unsigned DEPTH = BP_Q_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  bp_pred_t                         wdata,
  output bp_pred_t                         rdata,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  bp_pred_t             mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     cnt;
  logic                 do_push;
  logic                 do_pop;

  always_comb begin
    full    = (cnt == CNT_W'(DEPTH));
    empty   = (cnt == '0);
    do_pop  = pop & ~empty & ~flush;
    do_push = push & (~full | do_pop) & ~flush;
    rdata   = mem[rd_ptr];
    count   = cnt;
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bp_resolve_unit.sv
// Matches in-order EX resolutions against queued fetch predictions; drives predictor
// updates and a one-cycle flush/redirect on mispredict.
module bp_resolve_unit
  import riscv_bp_pkg::*;
#(
  parameter int unsigned PC_LEN  = BP_PC_LEN,
  parameter int unsigned Q_DEPTH = BP_Q_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_push,
  input  logic [PC_LEN-1:0] i_if_pc,
  input  logic              i_pred_valid,
  input  logic              i_pred_taken,
  input  logic [PC_LEN-1:0] i_pred_target,
  output logic              o_q_full,
  input  logic              i_ex_valid,
  input  logic              i_ex_is_branch,
  input  logic              i_ex_is_jump,
  input  logic              i_ex_taken,
  input  logic              i_ex_is_rvc,
  input  logic [PC_LEN-1:0] i_ex_pc,
  input  logic [PC_LEN-1:0] i_ex_target,
  output logic [PC_LEN-1:0] o_upd_pc,
  output logic [PC_LEN-1:0] o_upd_target,
  output logic              o_upd_branch,
  output logic              o_upd_taken,
  output logic              o_upd_jump,
  output logic              o_flush,
  output logic [PC_LEN-1:0] o_redirect_pc,
  output logic [31:0]       o_mispredict_cnt,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);

  bp_state_e          state_q;
  bp_state_e          state_d;
  bp_pred_t           push_entry;
  bp_pred_t           head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  logic               pop_req;
  logic               pop;
  logic               push_ok;
  logic               pred_eff;
  logic               actual;
  logic               mispredict;
  logic [PC_LEN-1:0]  head_target;
  logic [PC_LEN-1:0]  seq_pc;
  logic [PC_LEN-1:0]  redirect_d;
  logic [PC_LEN-1:0]  redirect_q;
  logic               unused_head_pc;

  // Queue entries are package-width; narrower PCs are zero-extended on the way in.
  always_comb begin
    push_entry             = '0;
    push_entry.pc          = BP_PC_LEN'(i_if_pc);
    push_entry.pred_valid  = i_pred_valid;
    push_entry.pred_taken  = i_pred_taken;
    push_entry.pred_target = BP_PC_LEN'(i_pred_target);
  end

  assign unused_head_pc = ^head.pc;

  // Resolve the head entry against the EX outcome.
  always_comb begin
    pop_req     = i_ex_valid & (state_q == BP_RUN);
    pop         = pop_req & ~fifo_empty;
    head_target = PC_LEN'(head.pred_target);
    pred_eff    = head.pred_valid & head.pred_taken;
    actual      = i_ex_is_jump | (i_ex_is_branch & i_ex_taken);
    mispredict  = pop & ((pred_eff != actual) |
                         (pred_eff & actual & (head_target != i_ex_target)));
    seq_pc      = i_ex_pc + (i_ex_is_rvc ? PC_LEN'(2) : PC_LEN'(4));
    redirect_d  = actual ? i_ex_target : seq_pc;
    // A push in the mispredict cycle is wrong-path and is dropped with the queue.
    push_ok     = i_if_push & (~fifo_full | pop) & ~mispredict;
    o_q_full    = (fifo_count == CNT_W'(Q_DEPTH));
  end

  bp_pred_fifo #(
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push_ok),
    .pop   (pop),
    .flush (mispredict),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= BP_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BP_RUN:     if (mispredict) state_d = BP_RECOVER;
      BP_RECOVER: state_d = BP_RUN;
      default:    state_d = BP_RUN;
    endcase
  end

  always_comb begin
    o_flush       = 1'b0;
    o_redirect_pc = '0;
    if (state_q == BP_RECOVER) begin
      o_flush       = 1'b1;
      o_redirect_pc = redirect_q;
    end
  end

  // Predictor update pulses, redirect capture, stats and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_upd_pc         <= '0;
      o_upd_target     <= '0;
      o_upd_branch     <= 1'b0;
      o_upd_taken      <= 1'b0;
      o_upd_jump       <= 1'b0;
      redirect_q       <= '0;
      o_mispredict_cnt <= '0;
      o_overflow       <= 1'b0;
      o_underflow      <= 1'b0;
    end else begin
      o_upd_branch <= pop & i_ex_is_branch & ~i_ex_is_jump;
      o_upd_jump   <= pop & i_ex_is_jump;
      o_upd_taken  <= pop & actual;
      if (pop && (i_ex_is_branch || i_ex_is_jump)) begin
        o_upd_pc     <= i_ex_pc;
        o_upd_target <= i_ex_target;
      end
      if (mispredict) begin
        redirect_q <= redirect_d;
        if (o_mispredict_cnt != 32'hFFFF_FFFF)
          o_mispredict_cnt <= o_mispredict_cnt + 32'd1;
      end
      if (i_if_push && fifo_full && !pop) o_overflow  <= 1'b1;
      if (pop_req && fifo_empty)          o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Scoreboard bench for bp_resolve_unit: a reference model queues expected outputs per cycle.
module tb_bp_resolve_unit;

  localparam int unsigned PCL = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           if_push, pred_valid, pred_taken;
  logic [PCL-1:0] if_pc, pred_target;
  logic           q_full;
  logic           ex_valid, ex_branch, ex_jump, ex_taken, ex_rvc;
  logic [PCL-1:0] ex_pc, ex_target;
  logic [PCL-1:0] upd_pc, upd_target, redirect_pc;
  logic           upd_branch, upd_taken, upd_jump, flush;
  logic [31:0]    mis_cnt;
  logic           overflow, underflow;

  always #5 clk = ~clk;

  bp_resolve_unit #(.PC_LEN(PCL), .Q_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_push(if_push), .i_if_pc(if_pc),
    .i_pred_valid(pred_valid), .i_pred_taken(pred_taken), .i_pred_target(pred_target),
    .o_q_full(q_full),
    .i_ex_valid(ex_valid), .i_ex_is_branch(ex_branch), .i_ex_is_jump(ex_jump),
    .i_ex_taken(ex_taken), .i_ex_is_rvc(ex_rvc), .i_ex_pc(ex_pc), .i_ex_target(ex_target),
    .o_upd_pc(upd_pc), .o_upd_target(upd_target), .o_upd_branch(upd_branch),
    .o_upd_taken(upd_taken), .o_upd_jump(upd_jump),
    .o_flush(flush), .o_redirect_pc(redirect_pc),
    .o_mispredict_cnt(mis_cnt), .o_overflow(overflow), .o_underflow(underflow)
  );

  typedef struct packed {
    logic [PCL-1:0] pc;
    logic           pv;
    logic           pt;
    logic [PCL-1:0] tgt;
  } mpred_t;

  typedef struct packed {
    logic           flush;
    logic [PCL-1:0] redirect;
    logic           ub;
    logic           uj;
    logic           ut;
    logic [PCL-1:0] upc;
    logic [PCL-1:0] utgt;
    logic [31:0]    cnt;
    logic           full;
    logic           ovf;
    logic           und;
  } exp_t;

  mpred_t         mq[$];
  exp_t           expq[$];
  logic           m_rec;
  logic [31:0]    m_cnt;
  logic           m_ovf, m_und;
  logic [PCL-1:0] m_redir;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference behaviour for one rising edge; returns the outputs expected just after it.
  task automatic model_edge(input logic r, input logic push, input mpred_t np,
                            input logic exv, input logic br, input logic jmp, input logic tk,
                            input logic rvc, input logic [PCL-1:0] expc,
                            input logic [PCL-1:0] extg, output exp_t e);
    mpred_t         h;
    logic           pop, misp, full, pe, act;
    logic [PCL-1:0] redir;
    e = '0; pop = 1'b0; misp = 1'b0; redir = '0;
    if (r) begin
      mq.delete(); m_rec = 1'b0; m_cnt = '0; m_ovf = 1'b0; m_und = 1'b0; m_redir = '0;
    end else begin
      full = (mq.size() == 4);
      if (exv && !m_rec) begin
        if (mq.size() == 0) m_und = 1'b1;
        else begin
          pop  = 1'b1;
          h    = mq.pop_front();
          pe   = h.pv & h.pt;
          act  = jmp | (br & tk);
          misp = (pe != act) || (pe && act && (h.tgt != extg));
          redir = act ? extg : expc + (rvc ? 64'd2 : 64'd4);
          e.ub = br & ~jmp; e.uj = jmp; e.ut = act; e.upc = expc; e.utgt = extg;
        end
      end
      if (misp) begin
        mq.delete();
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        m_redir = redir;
        m_rec = 1'b1;
      end else begin
        m_rec = 1'b0;
        if (push) begin
          if (full && !pop) m_ovf = 1'b1;
          else mq.push_back(np);
        end
      end
      e.flush    = m_rec;
      e.redirect = m_rec ? m_redir : '0;
    end
    e.cnt = m_cnt; e.full = (mq.size() == 4); e.ovf = m_ovf; e.und = m_und;
  endtask

  task automatic compare_head();
    exp_t e;
    if (expq.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = expq.pop_front();
    check_eq("flush", 64'(flush), 64'(e.flush));
    check_eq("redirect_pc", redirect_pc, e.redirect);
    check_eq("upd_branch", 64'(upd_branch), 64'(e.ub));
    check_eq("upd_jump", 64'(upd_jump), 64'(e.uj));
    check_eq("mispredict_cnt", 64'(mis_cnt), 64'(e.cnt));
    check_eq("q_full", 64'(q_full), 64'(e.full));
    check_eq("overflow", 64'(overflow), 64'(e.ovf));
    check_eq("underflow", 64'(underflow), 64'(e.und));
    if (e.ub) check_eq("upd_taken", 64'(upd_taken), 64'(e.ut));
    if (e.ub || e.uj) begin
      check_eq("upd_pc", upd_pc, e.upc);
      check_eq("upd_target", upd_target, e.utgt);
    end
  endtask

  task automatic step(input logic r, input logic push, input logic [PCL-1:0] pc,
                      input logic pv, input logic pt, input logic [PCL-1:0] ptg,
                      input logic exv, input logic br, input logic jmp, input logic tk,
                      input logic rvc, input logic [PCL-1:0] expc, input logic [PCL-1:0] extg);
    exp_t   e;
    mpred_t np;
    @(negedge clk);
    rst = r; if_push = push; if_pc = pc; pred_valid = pv; pred_taken = pt; pred_target = ptg;
    ex_valid = exv; ex_branch = br; ex_jump = jmp; ex_taken = tk; ex_rvc = rvc;
    ex_pc = expc; ex_target = extg;
    np = '{pc: pc, pv: pv, pt: pt, tgt: ptg};
    model_edge(r, push, np, exv, br, jmp, tk, rvc, expc, extg, e);
    expq.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic t_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic t_idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic t_push(input logic [PCL-1:0] pc, input logic pv, input logic pt,
                        input logic [PCL-1:0] tgt);
    step(1'b0, 1'b1, pc, pv, pt, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic t_ex(input logic br, input logic jmp, input logic tk, input logic rvc,
                      input logic [PCL-1:0] pc, input logic [PCL-1:0] tgt);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, br, jmp, tk, rvc, pc, tgt);
  endtask

  initial begin
    rst = 1'b1; if_push = 1'b0; if_pc = '0; pred_valid = 1'b0; pred_taken = 1'b0;
    pred_target = '0; ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_taken = 1'b0;
    ex_rvc = 1'b0; ex_pc = '0; ex_target = '0;
    m_rec = 1'b0; m_cnt = '0; m_ovf = 1'b0; m_und = 1'b0; m_redir = '0;

    t_reset();
    t_reset();
    check_eq("rst_flush", 64'(flush), 64'd0);
    check_eq("rst_cnt", 64'(mis_cnt), 64'd0);

    // Correct taken prediction: update only.
    t_push(64'h100, 1'b1, 1'b1, 64'h200);
    t_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 64'h200);
    check_eq("hit_upd_branch", 64'(upd_branch), 64'd1);
    check_eq("hit_upd_taken", 64'(upd_taken), 64'd1);
    check_eq("hit_no_flush", 64'(flush), 64'd0);
    t_idle();

    // No prediction, branch taken: flush to actual target.
    t_push(64'h100, 1'b0, 1'b0, 64'h0);
    t_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 64'h180);
    check_eq("miss_flush", 64'(flush), 64'd1);
    check_eq("miss_redirect", redirect_pc, 64'h180);
    check_eq("miss_cnt", 64'(mis_cnt), 64'd1);
    t_idle();
    check_eq("miss_flush_drop", 64'(flush), 64'd0);

    // Predicted taken, compressed branch falls through.
    t_push(64'h100, 1'b1, 1'b1, 64'h200);
    t_ex(1'b1, 1'b0, 1'b0, 1'b1, 64'h100, 64'h200);
    check_eq("rvc_redirect", redirect_pc, 64'h102);
    check_eq("rvc_upd_taken", 64'(upd_taken), 64'd0);

    // Jump to wrong target; wrong-path entry and EX-in-recover are discarded.
    t_push(64'h104, 1'b1, 1'b1, 64'h300);
    t_push(64'h108, 1'b0, 1'b0, 64'h0);
    t_ex(1'b0, 1'b1, 1'b1, 1'b0, 64'h104, 64'h340);
    check_eq("jmp_redirect", redirect_pc, 64'h340);
    check_eq("jmp_upd_jump", 64'(upd_jump), 64'd1);
    step(1'b0, 1'b1, 64'h340, 1'b1, 1'b1, 64'h500,
         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h108, 64'h777);
    t_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h340, 64'h500);
    check_eq("recover_push_kept", 64'(flush), 64'd0);

    // Fill, overflow, push+pop at full, then drain verifying order.
    t_push(64'h10, 1'b0, 1'b0, 64'h0);
    t_push(64'h14, 1'b1, 1'b1, 64'h1000);
    t_push(64'h18, 1'b0, 1'b0, 64'h0);
    t_push(64'h1c, 1'b1, 1'b1, 64'h3000);
    check_eq("fill_full", 64'(q_full), 64'd1);
    t_push(64'h20, 1'b1, 1'b1, 64'h9999);
    check_eq("ovf_sticky", 64'(overflow), 64'd1);
    step(1'b0, 1'b1, 64'h24, 1'b1, 1'b1, 64'h5000,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h10, 64'h0);
    check_eq("pushpop_full", 64'(q_full), 64'd1);
    t_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h14, 64'h1000);
    t_ex(1'b1, 1'b0, 1'b0, 1'b0, 64'h18, 64'h0);
    t_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h1c, 64'h3000);
    t_ex(1'b0, 1'b1, 1'b1, 1'b0, 64'h24, 64'h5000);
    check_eq("order_no_flush", 64'(flush), 64'd0);
    t_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h28, 64'h0);
    check_eq("und_sticky", 64'(underflow), 64'd1);

    // Reset while recovering aborts the flush.
    t_push(64'h200, 1'b0, 1'b0, 64'h0);
    t_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h200, 64'h800);
    check_eq("pre_rst_flush", 64'(flush), 64'd1);
    t_reset();
    check_eq("rst_rec_flush", 64'(flush), 64'd0);
    check_eq("rst_rec_cnt", 64'(mis_cnt), 64'd0);
    t_ex(1'b1, 1'b0, 1'b1, 1'b0, 64'h300, 64'h0);
    check_eq("rst_rec_empty", 64'(underflow), 64'd1);
    t_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_resolve_unit.md
BP_RESOLVE_UNIT -- requirements
Module: bp_resolve_unit

Interface
REQ-001 SHALL have parameter PC_LEN, default 64, PC/target width.
REQ-002 SHALL have parameter Q_DEPTH, default 4, in-flight prediction queue entries (power of 2, >=2).
REQ-003 SHALL have port i_clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_if_push  in  1  fetch slot accepted; record its prediction.
REQ-006 SHALL have port i_if_pc  in  PC_LEN  PC of fetched instruction.
REQ-007 SHALL have ports i_pred_valid, i_pred_taken  in  1 each  predictor hit / predicted taken.
REQ-008 SHALL have port i_pred_target  in  PC_LEN  predicted target.
REQ-009 SHALL have port o_q_full  out  1  queue full; fetch must stall.
REQ-010 SHALL have port i_ex_valid  in  1  an instruction completes EX this cycle (in order).
REQ-011 SHALL have ports i_ex_is_branch, i_ex_is_jump, i_ex_taken, i_ex_is_rvc  in  1 each  resolved class/outcome; rvc = 2-byte instruction.
REQ-012 SHALL have ports i_ex_pc, i_ex_target  in  PC_LEN each  resolved PC and actual target.
REQ-013 SHALL have ports o_upd_pc, o_upd_target (PC_LEN), o_upd_branch, o_upd_taken, o_upd_jump (1)  out  predictor update port.
REQ-014 SHALL have ports o_flush (1), o_redirect_pc (PC_LEN)  out  pipeline flush and refetch address.
REQ-015 SHALL have ports o_mispredict_cnt (32), o_overflow (1), o_underflow (1)  out  stats / sticky errors.

Function
REQ-016 SHALL push {pc, pred_valid, pred_taken, pred_target} on i_if_push when not full or when a pop occurs the same cycle.
REQ-017 SHALL pop the head entry on i_ex_valid when state is RUN and queue is non-empty.
REQ-018 SHALL compute pred_eff = head.pred_valid & head.pred_taken; actual = i_ex_is_jump | (i_ex_is_branch & i_ex_taken).
REQ-019 SHALL flag mispredict when pred_eff != actual, or pred_eff & actual & head.pred_target != i_ex_target.
REQ-020 SHALL set redirect = actual ? i_ex_target : i_ex_pc + (i_ex_is_rvc ? 2 : 4), modulo 2^PC_LEN.
REQ-021 SHALL, on a pop of a branch, drive next cycle o_upd_branch=1, o_upd_taken=i_ex_taken, o_upd_pc=i_ex_pc, o_upd_target=i_ex_target; for a jump, o_upd_jump=1 instead; both pulses one cycle; non-control pops produce no update.
REQ-022 SHALL implement FSM RUN/RECOVER: RUN->RECOVER on mispredict pop; RECOVER->RUN unconditionally next cycle.
REQ-023 SHALL assert o_flush and o_redirect_pc only during RECOVER (1-cycle latency after detection).
REQ-024 SHALL empty the queue at the mispredict edge and discard any same-cycle push (wrong path).
REQ-025 SHALL ignore i_ex_valid in RECOVER (wrong-path instruction); pushes in RECOVER are accepted.
REQ-026 SHALL increment o_mispredict_cnt per mispredict, saturating at 0xFFFF_FFFF.
REQ-027 SHALL drop a push while full without pop and set sticky o_overflow; SHALL ignore a pop while empty and set sticky o_underflow.
REQ-028 SHALL assert o_q_full combinationally from count == Q_DEPTH; pointers wrap modulo Q_DEPTH.

Reset
REQ-029 SHALL, while i_rst=1 at an edge, set state RUN, queue empty, all o_upd_*/o_flush 0, o_redirect_pc 0, o_mispredict_cnt 0, o_overflow/o_underflow 0; reset mid-recovery aborts the flush.

Structure
REQ-030 SHALL take PC_LEN default and typedef bp_pred_t {pc, pred_valid, pred_taken, pred_target} from shared package riscv_bp_pkg; FSM enum there too.
REQ-031 SHALL instantiate one sub-module bp_pred_fifo (sync FIFO of bp_pred_t, push/pop/flush, full/empty/count).

Verification
REQ-032 Push pc=0x100 pred_valid=1 taken=1 target=0x200; EX branch taken target 0x200 -> no flush, next cycle o_upd_branch=1 o_upd_taken=1, cnt stays 0.
REQ-033 Push pc=0x100 pred_valid=0; EX branch taken target 0x180 -> next cycle o_flush=1, o_redirect_pc=0x180, queue empty, cnt=1.
REQ-034 Predicted taken 0x200, EX branch not taken, i_ex_is_rvc=1, pc 0x100 -> o_redirect_pc=0x102, o_upd_taken=0.
REQ-035 Jump predicted 0x300, actual 0x340 -> flush redirect 0x340, o_upd_jump=1; EX valid during RECOVER ignored (no pop).
REQ-036 Fill 4 entries, push without pop -> o_q_full=1, o_overflow=1, count 4; simultaneous push+pop at full -> count stays 4, order preserved.
REQ-037 Assert i_rst during RECOVER -> next cycle o_flush=0, cnt=0, queue empty, state RUN.
